// File: rtl/micro_sequencer.sv
// Microstep sequencer: step counter, flag latch, retired count, RUN/HALT/PROG control.
// Zero-latency instout; optional early instruction end when SEQ_EARLY_END_EN is defined.
// No backpressure: pmode freezes state, HALT is left only through clr.
module micro_sequencer #(
  parameter int STEPS = 5
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       pmode,
  input  logic [3:0] opcode,
  input  logic       cf,
  input  logic       zf,
  input  logic       flagsin,
  input  logic       hlt,
  input  logic       cwzero,
  output logic [8:0] instout,
  output logic [2:0] step,
  output logic       halted,
  output logic [7:0] retired
);

  localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_HALT = 2'd1,
    S_PROG = 2'd2
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_step, w_step_nxt;
  logic       r_cf, r_zf, w_cf_nxt, w_zf_nxt;
  logic [7:0] r_retired, w_retired_nxt;
  logic       w_early;

`ifdef SEQ_EARLY_END_EN
  assign w_early = (r_step >= 3'd2) && cwzero;
`else
  logic w_unused_cwzero;
  assign w_unused_cwzero = cwzero;
  assign w_early = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_step_nxt    = r_step;
    w_cf_nxt      = r_cf;
    w_zf_nxt      = r_zf;
    w_retired_nxt = r_retired;
    // Leaving PROG with pmode low is itself an ordinary RUN edge.
    if (r_state != S_HALT) begin
      if (pmode) begin
        w_state_nxt = S_PROG;
      end else begin
        w_state_nxt = hlt ? S_HALT : S_RUN;
        if (flagsin) begin
          w_cf_nxt = cf;
          w_zf_nxt = zf;
        end
        if (!hlt) begin
          if ((r_step == LAST_STEP) || w_early) begin
            w_step_nxt = 3'd0;
            if (r_retired != 8'hFF) w_retired_nxt = r_retired + 8'd1;
          end else begin
            w_step_nxt = r_step + 3'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state   <= S_RUN;
      r_step    <= 3'd0;
      r_cf      <= 1'b0;
      r_zf      <= 1'b0;
      r_retired <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_step    <= w_step_nxt;
      r_cf      <= w_cf_nxt;
      r_zf      <= w_zf_nxt;
      r_retired <= w_retired_nxt;
    end
  end

  assign instout = {opcode, r_step, r_cf, r_zf};
  assign step    = r_step;
  assign halted  = (r_state == S_HALT);
  assign retired = r_retired;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer (STEPS=5); honours SEQ_EARLY_END_EN if defined.
module tb_micro_sequencer;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       pmode = 1'b0;
  logic [3:0] opcode = 4'h2;
  logic       cf = 1'b0;
  logic       zf = 1'b0;
  logic       flagsin = 1'b0;
  logic       hlt = 1'b0;
  logic       cwzero = 1'b0;
  logic [8:0] instout;
  logic [2:0] step;
  logic       halted;
  logic [7:0] retired;

  int n_chk = 0;
  int n_err = 0;

  micro_sequencer #(.STEPS(5)) dut (
    .clk(clk), .clr(clr), .pmode(pmode), .opcode(opcode), .cf(cf), .zf(zf),
    .flagsin(flagsin), .hlt(hlt), .cwzero(cwzero),
    .instout(instout), .step(step), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    // Reset state
    #7;
    chk("rst_step", 9'(step), 9'd0);
    chk("rst_halted", 9'(halted), 9'd0);
    chk("rst_retired", 9'(retired), 9'd0);
    chk("rst_instout", instout, 9'b0010_000_00);
    clr = 1'b1;

    // Basic sequencing: step after edge k is k mod 5
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("seq_step%0d", k), 9'(step), 9'(k % 5));
      if (k == 10) chk("seq_retired10", 9'(retired), 9'd2);
    end

    // Flag latch at step 4 coincides with wrap
    tick(); tick();
    chk("pre_flag_step", 9'(step), 9'd4);
    cf = 1'b1; zf = 1'b0; flagsin = 1'b1;
    tick();
    flagsin = 1'b0;
    chk("flag_latch", 9'(instout[1:0]), 9'b10);
    chk("flag_wrap_step", 9'(step), 9'd0);
    chk("flag_wrap_retired", 9'(retired), 9'd3);
    cf = 1'b0; zf = 1'b1;
    tick();
    chk("flag_hold", 9'(instout[1:0]), 9'b10);
    opcode = 4'hA;
    #1;
    chk("opcode_comb", instout, 9'b1010_001_10);

    // cwzero at step 1 never ends early; at step 2 only with the feature
    cwzero = 1'b1;
    tick();
    chk("cwz_step1", 9'(step), 9'd2);
    tick();
    cwzero = 1'b0;
`ifdef SEQ_EARLY_END_EN
    chk("cwz_step2", 9'(step), 9'd0);
    chk("cwz_retired", 9'(retired), 9'd4);
`else
    chk("cwz_step2", 9'(step), 9'd3);
    chk("cwz_retired", 9'(retired), 9'd3);
`endif

    // Async reset mid-cycle
    clr = 1'b0;
    #1;
    chk("clr1_step", 9'(step), 9'd0);
    chk("clr1_retired", 9'(retired), 9'd0);
    chk("clr1_flags", 9'(instout[1:0]), 9'd0);
    #1;
    clr = 1'b1;

    // PROG: pmode beats hlt, step holds, resumes from held step
    tick(); tick();
    chk("prog_pre", 9'(step), 9'd2);
    pmode = 1'b1; hlt = 1'b1;
    tick();
    hlt = 1'b0;
    chk("prog_nohalt", 9'(halted), 9'd0);
    chk("prog_hold0", 9'(step), 9'd2);
    for (int k = 0; k < 5; k++) tick();
    chk("prog_hold5", 9'(step), 9'd2);
    chk("prog_retired", 9'(retired), 9'd0);
    pmode = 1'b0;
    tick();
    chk("prog_resume", 9'(step), 9'd3);

    // HALT with flag update on the halt edge
    hlt = 1'b1; flagsin = 1'b1; cf = 1'b1; zf = 1'b1;
    tick();
    hlt = 1'b0; flagsin = 1'b0;
    chk("halt_on", 9'(halted), 9'd1);
    chk("halt_step", 9'(step), 9'd3);
    chk("halt_flags", 9'(instout[1:0]), 9'b11);
    for (int k = 0; k < 20; k++) begin
      pmode = ~pmode;
      tick();
    end
    pmode = 1'b0;
    tick();
    chk("halt_stay", 9'(halted), 9'd1);
    chk("halt_step20", 9'(step), 9'd3);
    clr = 1'b0;
    #2;
    chk("clr2_instout", instout, 9'b1010_000_00);
    chk("clr2_halted", 9'(halted), 9'd0);
    chk("clr2_retired", 9'(retired), 9'd0);
    clr = 1'b1;

    // First edge after reset, then saturation over 300 instructions
    tick();
    chk("post_clr_step", 9'(step), 9'd1);
    for (int k = 0; k < 1499; k++) tick();
    chk("sat_step", 9'(step), 9'd0);
    chk("sat_retired", 9'(retired), 9'd255);
    tick(); tick(); tick();
    chk("sat_step3", 9'(step), 9'd3);
    chk("sat_hold", 9'(retired), 9'd255);
    clr = 1'b0;
    #1;
    chk("clr3_step", 9'(step), 9'd0);
    chk("clr3_retired", 9'(retired), 9'd0);
    #1;
    clr = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
